cache_fill_wb_ctrl: RTL

CACHE_FILL_WB_CTRL -- requirements
Module: cache_fill_wb_ctrl

---
 rtl/cache_fill_wb_ctrl_if.sv | 49 ++++
 rtl/cache_fill_wb_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cache_fill_wb_ctrl_if.sv
// Bus bundle between the cache miss controller and its cache arrays / memory port.
interface cache_fill_wb_ctrl_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned WORDS   = 8,
    parameter int unsigned INDEX_W = 6
);
    localparam int unsigned BO_W  = $clog2(DATA_W / 8);
    localparam int unsigned WO_W  = $clog2(WORDS);
    localparam int unsigned TAG_W = ADDR_W - INDEX_W - WO_W - BO_W;

    // miss / victim side
    logic                miss_detected;
    logic [ADDR_W-1:0]   miss_address;
    logic                victim_dirty;
    logic [TAG_W-1:0]    victim_tag;
    logic [DATA_W-1:0]   victim_data;

    // memory side
    logic                mem_ready;
    logic [DATA_W-1:0]   mem_data;
    logic                mem_data_valid;
    logic                mem_rd_en;
    logic                mem_wr_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wr_data;

    // cache array control
    logic                fsm_busy;
    logic [WO_W-1:0]     word_idx;
    logic                write_data_array;
    logic                write_tag_array;
    logic [TAG_W+1:0]    tag_in;

    // mem_data feeds the data array directly; the controller only sequences it
    modport master (
        input  miss_detected, miss_address, victim_dirty, victim_tag, victim_data,
        input  mem_ready, mem_data_valid,
        output fsm_busy, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
        output word_idx, write_data_array, write_tag_array, tag_in
    );

    modport slave (
        output miss_detected, miss_address, victim_dirty, victim_tag, victim_data,
        output mem_ready, mem_data, mem_data_valid,
        input  fsm_busy, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
        input  word_idx, write_data_array, write_tag_array, tag_in
    );
endinterface

// File: rtl/cache_fill_wb_ctrl.sv
// Cache miss controller: optional dirty-victim write-back, pipelined line fill, tag update.
module cache_fill_wb_ctrl #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned WORDS   = 8,
    parameter int unsigned INDEX_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cache_fill_wb_ctrl_if.master  bus
);
    localparam int unsigned BO_W   = $clog2(DATA_W / 8);
    localparam int unsigned WO_W   = $clog2(WORDS);
    localparam int unsigned OFF_W  = WO_W + BO_W;
    localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFF_W;
    localparam int unsigned LINE_W = ADDR_W - OFF_W;
    localparam int unsigned CNT_W  = WO_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2,
        S_TAGW = 2'd3
    } state_t;

    state_t              r_state;
    logic [LINE_W-1:0]   r_line;
    logic [TAG_W-1:0]    r_vtag;
    logic [CNT_W-1:0]    r_wb_cnt;
    logic [CNT_W-1:0]    r_req_cnt;
    logic [CNT_W-1:0]    r_rsp_cnt;

    logic                w_last_wb;
    logic                w_req_pend;
    logic                w_last_rsp;
    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_ltag;
    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   w_wb_addr;
    logic [ADDR_W-1:0]   w_rd_addr;

    logic                w_busy;
    logic                w_rd_en;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wr_data;
    logic [WO_W-1:0]     w_word_idx;
    logic                w_wda;
    logic                w_wta;

    // Line address pieces and counter end conditions
    assign w_last_wb  = (r_wb_cnt == CNT_W'(WORDS - 1));
    assign w_req_pend = (r_req_cnt < CNT_W'(WORDS));
    assign w_last_rsp = (r_rsp_cnt == CNT_W'(WORDS - 1));
    assign w_index    = r_line[INDEX_W-1:0];
    assign w_ltag     = r_line[LINE_W-1:INDEX_W];
    assign w_base     = ADDR_W'(r_line) << OFF_W;
    assign w_wb_addr  = (ADDR_W'(r_vtag) << (INDEX_W + OFF_W))
                      | (ADDR_W'(w_index) << OFF_W)
                      | (ADDR_W'(r_wb_cnt[WO_W-1:0]) << BO_W);
    assign w_rd_addr  = w_base + (ADDR_W'(r_req_cnt) << BO_W);

    // State, counters and captured miss context
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_line    <= '0;
            r_vtag    <= '0;
            r_wb_cnt  <= '0;
            r_req_cnt <= '0;
            r_rsp_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wb_cnt  <= '0;
                    r_req_cnt <= '0;
                    r_rsp_cnt <= '0;
                    if (bus.miss_detected) begin
                        r_line  <= bus.miss_address[ADDR_W-1:OFF_W];
                        r_vtag  <= bus.victim_tag;
                        r_state <= bus.victim_dirty ? S_WB : S_FILL;
                    end
                end
                S_WB: begin
                    if (bus.mem_ready) begin
                        if (w_last_wb) begin
                            r_state   <= S_FILL;
                            r_wb_cnt  <= '0;
                            r_req_cnt <= '0;
                            r_rsp_cnt <= '0;
                        end else begin
                            r_wb_cnt <= r_wb_cnt + CNT_W'(1);
                        end
                    end
                end
                S_FILL: begin
                    // requests and responses progress independently
                    if (w_req_pend) begin
                        r_req_cnt <= r_req_cnt + CNT_W'(1);
                    end
                    if (bus.mem_data_valid) begin
                        r_rsp_cnt <= r_rsp_cnt + CNT_W'(1);
                        if (w_last_rsp) begin
                            r_state <= S_TAGW;
                        end
                    end
                end
                S_TAGW: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode from current state; everything idles at zero
    always_comb begin
        w_busy     = 1'b0;
        w_rd_en    = 1'b0;
        w_wr_en    = 1'b0;
        w_addr     = '0;
        w_wr_data  = '0;
        w_word_idx = '0;
        w_wda      = 1'b0;
        w_wta      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // stall the pipeline in the capture cycle, but never during reset
                w_busy = rst_n & bus.miss_detected;
            end
            S_WB: begin
                w_busy     = 1'b1;
                w_wr_en    = 1'b1;
                w_addr     = w_wb_addr;
                w_wr_data  = bus.victim_data;
                w_word_idx = r_wb_cnt[WO_W-1:0];
            end
            S_FILL: begin
                w_busy     = 1'b1;
                w_rd_en    = w_req_pend;
                w_addr     = w_req_pend ? w_rd_addr : '0;
                w_word_idx = r_rsp_cnt[WO_W-1:0];
                w_wda      = bus.mem_data_valid;
            end
            S_TAGW: begin
                w_wta = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    assign bus.fsm_busy         = w_busy;
    assign bus.mem_rd_en        = w_rd_en;
    assign bus.mem_wr_en        = w_wr_en;
    assign bus.mem_addr         = w_addr;
    assign bus.mem_wr_data      = w_wr_data;
    assign bus.word_idx         = w_word_idx;
    assign bus.write_data_array = w_wda;
    assign bus.write_tag_array  = w_wta;
    assign bus.tag_in           = {w_ltag, 1'b1, 1'b0};

endmodule
